mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-side responder for the multicycle RISC-V core's control sequencer. Accepts one fetch, load or store request at a time and runs it as a single word-wide bus transaction with arbitrary wait states. Performs byte-lane steering, byte enables, sign/zero extension and alignment checks. Returns a one-cycle completion pulse that drives the sequencer's memory-ready input.

## Interface
- TIMEOUT, 16: bus-ack watchdog limit in cycles, 1..255; used only with MEM_TIMEOUT_EN.
- iClk  in  1  clock, rising edge.
- nRst  in  1  asynchronous, active-low reset.
- iFetch  in  1  instruction fetch request (level), word access.
- iLoad  in  1  data load request (level).
- iStore  in  1  data store request (level).
- iAddr  in  32  byte address.
- iFunct3  in  3  access size/sign for load/store; ignored for fetch.
- iWData  in  32  store data, value in low bits.
- oRdy  out  1  one-cycle completion pulse; feeds the sequencer's memory-ready input.
- oRData  out  32  aligned, extended load data or instruction word.
- oErr  out  1  high with oRdy when the access faulted.
- oBusReq  out  1  bus request, held until ack.
- oBusWe  out  1  bus write enable.
- oBusAddr  out  32  word address, bits [1:0] = 0.
- oBusBe  out  4  byte enables; bit n = byte lane n.
- oBusWData  out  32  lane-steered write data.
- iBusAck  in  1  bus completion; read data valid in the same cycle.
- iBusRData  in  32  bus read data.

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE: sample requests each edge. Priority is fetch > load > store. The winning request, iAddr, iFunct3 and iWData are latched.
- Decode on latch:
  - Fetch is LW.
  - Load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store funct3 values: 000 SB, 001 SH, 010 SW.
- Illegal funct3 (load 011/110/111; store 011 or 1xx), halfword with addr[0]=1, or word with addr[1:0]≠0: go to FAULT. No bus activity.
- Legal request: go to REQ.
- Byte enables: byte = 0001<<a[1:0]; half = 0011<<a[1:0]; word = 1111. a is the latched addr[1:0]. Loads use the same enables.
- Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
- REQ: oBusReq=1. oBusWe=1 for stores only. oBusAddr, oBusBe and oBusWData are held stable. On iBusAck=1, capture data and go to DONE.
- Load data path:
  - Shift iBusRData right by 8·a[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW/fetch pass the word unchanged.
- oRData is a register. It updates only when a load/fetch captures data. A store leaves it unchanged. FAULT clears it to 0.
- DONE: oRdy=1, oErr=0, bus outputs deasserted, then IDLE.
- FAULT: oRdy=1, oErr=1, then IDLE.
- iBusAck outside REQ is ignored.

## Timing
- Reset values: oRdy=0, oErr=0, oRData=0, oBusReq=0, oBusWe=0, oBusAddr=0, oBusBe=0, oBusWData=0. State is IDLE.
- Latency:
  - Request sampled at edge 0 gives oBusReq high in cycle 1.
  - Ack sampled at edge k≥1 gives oRdy high in cycle k+1. Minimum is 2 cycles from request edge to oRdy cycle.
  - Fault gives oRdy one cycle after the request edge.
- oRdy is exactly one cycle wide. The block accepts a new request in the first IDLE cycle after DONE/FAULT. The requester must change or drop its request level on the edge where oRdy=1.
- Requests arriving in REQ/DONE/FAULT are not queued. Input changes during REQ have no effect on the latched access.
- Reset asserted mid-transaction drops oBusReq immediately (asynchronously) and abandons the access. No oRdy is generated.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT with no ack, the FSM goes to FAULT: oBusReq drops, oRdy=1 and oErr=1, and oRData is cleared.
  - An ack in the same cycle as the limit wins; the access completes normally.
- Undefined: no counter; REQ waits indefinitely for iBusAck.

## Test plan
- Fetch at 0x0000_0100, ack after 3 wait cycles with RData 0x0010_0093 -> oBusAddr=0x100, oBusBe=1111, oBusWe=0; oRData=0x0010_0093 and oRdy one cycle, the cycle after ack.
- LB at 0x203, RData 0x80FF_0000 -> oRData=0xFFFF_FF80. LBU at the same address -> oRData=0x0000_0080. LHU at 0x202 -> oRData=0x0000_80FF.
- SB at 0x301, iWData=0x1234_56AB -> oBusAddr=0x300, oBusBe=0010, oBusWData=0xABAB_ABAB, oBusWe=1; oRData unchanged.
- LW at 0x402 and SH at 0x405 -> no oBusReq; oRdy=oErr=1 one cycle after request; oRData=0.
- iFetch and iStore both high -> fetch served first. Store served in the next IDLE if still requested. Reset mid-REQ -> oBusReq=0 at once and no oRdy.
- With MEM_TIMEOUT_EN and TIMEOUT=4, never ack -> oErr+oRdy after 4 REQ cycles. Repeat with ack on the 4th cycle -> normal completion, oErr=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and word-bus signals of mem_access_unit.
// slave: the memory access unit itself; master: the sequencer plus bus model driving it.
interface mem_access_unit_if;
   logic        iFetch;
   logic        iLoad;
   logic        iStore;
   logic [31:0] iAddr;
   logic [2:0]  iFunct3;
   logic [31:0] iWData;
   logic        oRdy;
   logic [31:0] oRData;
   logic        oErr;
   logic        oBusReq;
   logic        oBusWe;
   logic [31:0] oBusAddr;
   logic [3:0]  oBusBe;
   logic [31:0] oBusWData;
   logic        iBusAck;
   logic [31:0] iBusRData;

   modport slave (
      input  iFetch, iLoad, iStore, iAddr, iFunct3, iWData, iBusAck, iBusRData,
      output oRdy, oRData, oErr, oBusReq, oBusWe, oBusAddr, oBusBe, oBusWData
   );

   modport master (
      output iFetch, iLoad, iStore, iAddr, iFunct3, iWData, iBusAck, iBusRData,
      input  oRdy, oRData, oErr, oBusReq, oBusWe, oBusAddr, oBusBe, oBusWData
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one fetch/load/store at a time as a single word-wide
// bus transaction, with lane steering, byte enables, load extension and
// alignment faults. Returns a one-cycle oRdy pulse (with oErr on faults).
// Optional feature: define MEM_TIMEOUT_EN to enable the bus-ack watchdog
// that faults an access after TIMEOUT request cycles without iBusAck.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             iClk,
   input  logic             nRst,
   mem_access_unit_if.slave bus
);

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned CW  = 8;

   // The watchdog limit must fit the 8-bit request-cycle counter.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             rdy_q, rdy_d;
   logic             err_q, err_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [AW-1:0]    bus_addr_q, bus_addr_d;
   logic [BEW-1:0]   bus_be_q, bus_be_d;
   logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       alo_q, alo_d;
   logic             is_st_q, is_st_d;

   logic             req_any_c;
   logic             st_win_c;
   logic [2:0]       f3_c;
   logic [1:0]       a_c;
   logic             f3_ok_c;
   logic             misal_c;
   logic             bad_c;
   logic [BEW-1:0]   be_c;
   logic [DW-1:0]    wdata_c;
   logic [DW-1:0]    ld_shift_c;
   logic [DW-1:0]    ld_ext_c;

`ifdef MEM_TIMEOUT_EN
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tmo_c;

   // Limit reached when this REQ cycle would be the TIMEOUT-th without ack.
   assign tmo_c = (CW'(cnt_q + CW'(1)) == CW'(TIMEOUT));
`endif

   // Request arbitration and access decode of the live inputs (used in IDLE).
   always_comb begin
      req_any_c = bus.iFetch | bus.iLoad | bus.iStore;
      st_win_c  = ~bus.iFetch & ~bus.iLoad & bus.iStore;
      f3_c      = bus.iFetch ? 3'b010 : bus.iFunct3;
      a_c       = bus.iAddr[1:0];
      if (st_win_c) begin
         f3_ok_c = (f3_c[2] == 1'b0) && (f3_c[1:0] != 2'b11);
      end else begin
         f3_ok_c = (f3_c[1:0] != 2'b11) && !(f3_c[2] && f3_c[1]);
      end
      misal_c = ((f3_c[1:0] == 2'b01) && a_c[0]) ||
                ((f3_c[1:0] == 2'b10) && (a_c != 2'b00));
      bad_c   = ~f3_ok_c | misal_c;
      case (f3_c[1:0])
         2'b00:   be_c = BEW'(4'b0001 << a_c);
         2'b01:   be_c = BEW'(4'b0011 << a_c);
         default: be_c = 4'b1111;
      endcase
      case (f3_c[1:0])
         2'b00:   wdata_c = {4{bus.iWData[7:0]}};
         2'b01:   wdata_c = {2{bus.iWData[15:0]}};
         default: wdata_c = bus.iWData;
      endcase
   end

   // Load data alignment and sign/zero extension from the latched access.
   always_comb begin
      ld_shift_c = bus.iBusRData >> {alo_q, 3'b000};
      case (f3_q)
         3'b000:  ld_ext_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
         3'b001:  ld_ext_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
         3'b100:  ld_ext_c = {24'd0, ld_shift_c[7:0]};
         3'b101:  ld_ext_c = {16'd0, ld_shift_c[15:0]};
         default: ld_ext_c = ld_shift_c;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      rdy_d       = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      f3_d        = f3_q;
      alo_d       = alo_q;
      is_st_d     = is_st_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_any_c) begin
               f3_d    = f3_c;
               alo_d   = a_c;
               is_st_d = st_win_c;
               if (bad_c) begin
                  state_d = FAULT;
                  rdy_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d     = REQ;
                  bus_req_d   = 1'b1;
                  bus_we_d    = st_win_c;
                  bus_addr_d  = {bus.iAddr[AW-1:2], 2'b00};
                  bus_be_d    = be_c;
                  bus_wdata_d = wdata_c;
`ifdef MEM_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end
            end
         end
         REQ: begin
            if (bus.iBusAck) begin
               state_d     = DONE;
               rdy_d       = 1'b1;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_be_d    = '0;
               bus_wdata_d = '0;
               if (!is_st_q) begin
                  rdata_d = ld_ext_c;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_c) begin
               state_d     = FAULT;
               rdy_d       = 1'b1;
               err_d       = 1'b1;
               rdata_d     = '0;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_be_d    = '0;
               bus_wdata_d = '0;
            end else begin
               cnt_d = CW'(cnt_q + CW'(1));
            end
`endif
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops the bus request immediately.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         f3_q        <= '0;
         alo_q       <= '0;
         is_st_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         f3_q        <= f3_d;
         alo_q       <= alo_d;
         is_st_q     <= is_st_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Watchdog counter of REQ cycles without ack.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.oRdy      = rdy_q;
   assign bus.oErr      = err_q;
   assign bus.oRData    = rdata_q;
   assign bus.oBusReq   = bus_req_q;
   assign bus.oBusWe    = bus_we_q;
   assign bus.oBusAddr  = bus_addr_q;
   assign bus.oBusBe    = bus_be_q;
   assign bus.oBusWData = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses checked against a behavioural model of the access rules.
module tb_mem_access_unit;

   localparam int unsigned TO = 4;

   logic iClk = 1'b0;
   logic nRst;
   always #5 iClk = ~iClk;

   mem_access_unit_if bus ();

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .iClk (iClk),
      .nRst (nRst),
      .bus  (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_rdata;

   typedef struct {
      bit          req_seen;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          stable;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      bit          width_ok;
   } obs_t;

   // Behavioural model: what one access should do, from the ISA-level rules.
   function automatic void ref_model(input bit f, input bit l, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     input logic [31:0] rd, output bit is_st,
                                     output bit fault, output logic [3:0] be,
                                     output logic [31:0] bw, output logic [31:0] ld);
      int     size;
      bit     sgn;
      bit     legal;
      int     off;
      longint v;
      size  = 4;
      sgn   = 1'b0;
      legal = 1'b1;
      off   = int'(addr % 32'd4);
      is_st = !f && !l;
      if (f) begin
         size = 4;
      end else if (l) begin
         case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: legal = 1'b0;
         endcase
      end else begin
         case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            default: legal = 1'b0;
         endcase
      end
      fault = !legal || ((off % size) != 0);
      be    = 4'(((1 << size) - 1) << off);
      if (size == 1)      bw = 32'(wd[7:0]) * 32'h0101_0101;
      else if (size == 2) bw = 32'(wd[15:0]) * 32'h0001_0001;
      else                bw = wd;
      v = longint'(rd >> (8 * off));
      if (size < 4) v = v % (longint'(1) << (8 * size));
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      ld = 32'(v);
   endfunction

   // Drive one request, play the bus with `waits` wait cycles, observe everything.
   task automatic run_access(input bit f, input bit l, input bit s, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] wd, input int waits,
                             input logic [31:0] rd, output obs_t o);
      int nreq;
      o.req_seen = 1'b0; o.we = 1'b0; o.addr = '0; o.be = '0; o.wdata = '0;
      o.stable = 1'b1; o.lat = -1; o.err = 1'b0; o.rdata = '0; o.width_ok = 1'b0;
      @(negedge iClk);
      bus.iFetch = f; bus.iLoad = l; bus.iStore = s;
      bus.iAddr = addr; bus.iFunct3 = f3; bus.iWData = wd; bus.iBusAck = 1'b0;
      @(posedge iClk); #1;
      bus.iFetch = 1'b0; bus.iLoad = 1'b0; bus.iStore = 1'b0;
      bus.iAddr = $urandom; bus.iFunct3 = 3'($urandom); bus.iWData = $urandom;
      nreq = 0;
      for (int cyc = 1; cyc <= 64; cyc++) begin
         bus.iBusAck = 1'b0;
         bus.iBusRData = $urandom;
         if (bus.oRdy === 1'b1) begin
            o.lat = cyc; o.err = bus.oErr; o.rdata = bus.oRData;
            break;
         end
         if (bus.oBusReq === 1'b1) begin
            if (!o.req_seen) begin
               o.we = bus.oBusWe; o.addr = bus.oBusAddr; o.be = bus.oBusBe; o.wdata = bus.oBusWData;
            end else if (o.we !== bus.oBusWe || o.addr !== bus.oBusAddr ||
                         o.be !== bus.oBusBe || o.wdata !== bus.oBusWData) begin
               o.stable = 1'b0;
            end
            o.req_seen = 1'b1;
            nreq++;
            if (nreq > waits) begin
               bus.iBusAck = 1'b1;
               bus.iBusRData = rd;
            end
         end
         @(posedge iClk); #1;
      end
      bus.iBusAck = 1'b0;
      if (o.lat > 0) begin
         @(posedge iClk); #1;
         o.width_ok = (bus.oRdy === 1'b0) && (bus.oBusReq === 1'b0);
      end
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      bus.iFetch = 1'b0; bus.iLoad = 1'b0; bus.iStore = 1'b0;
      bus.iAddr = '0; bus.iFunct3 = '0; bus.iWData = '0;
      bus.iBusAck = 1'b0; bus.iBusRData = '0;
      repeat (3) @(posedge iClk);
      #1;
      n_cmp++;
      if ({bus.oRdy, bus.oErr, bus.oBusReq, bus.oBusWe, bus.oBusBe} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_ctrl got %b want 00000000",
                  {bus.oRdy, bus.oErr, bus.oBusReq, bus.oBusWe, bus.oBusBe});
      end
      n_cmp++;
      if (bus.oRData !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata got %h want 00000000", bus.oRData);
      end
      n_cmp++;
      if (bus.oBusAddr !== 32'h0 || bus.oBusWData !== 32'h0) begin
         n_err++; $display("FAIL reset_bus got %h/%h want 0/0", bus.oBusAddr, bus.oBusWData);
      end
      @(negedge iClk); nRst = 1'b1;
      @(negedge iClk); bus.iBusAck = 1'b1; bus.iBusRData = 32'hDEAD_BEEF;
      repeat (2) @(posedge iClk);
      #1;
      n_cmp++;
      if (bus.oRdy !== 1'b0 || bus.oBusReq !== 1'b0 || bus.oRData !== 32'h0) begin
         n_err++;
         $display("FAIL idle_ack got rdy=%b req=%b rdata=%h want 0 0 0",
                  bus.oRdy, bus.oBusReq, bus.oRData);
      end
      bus.iBusAck = 1'b0;
      exp_rdata = 32'h0;
   endtask

   task automatic test_fetch();
      obs_t o;
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 3'b111, 32'h5555_AAAA, 3, 32'h0010_0093, o);
      n_cmp++;
      if (!o.req_seen || o.we !== 1'b0 || o.addr !== 32'h100 || o.be !== 4'b1111) begin
         n_err++;
         $display("FAIL fetch_bus got req=%0d we=%b addr=%h be=%b want 1 0 00000100 1111",
                  o.req_seen, o.we, o.addr, o.be);
      end
      n_cmp++;
      if (o.lat !== 5) begin
         n_err++; $display("FAIL fetch_lat got %0d want 5", o.lat);
      end
      n_cmp++;
      if (o.rdata !== 32'h0010_0093 || o.err !== 1'b0) begin
         n_err++; $display("FAIL fetch_data got %h err=%b want 00100093 err=0", o.rdata, o.err);
      end
      n_cmp++;
      if (!o.width_ok || !o.stable) begin
         n_err++; $display("FAIL fetch_pulse got width_ok=%0d stable=%0d want 1 1", o.width_ok, o.stable);
      end
      exp_rdata = 32'h0010_0093;
   endtask

   task automatic test_loads();
      obs_t        o;
      logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
      logic [31:0] ads [3] = '{32'h203, 32'h203, 32'h202};
      logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      logic [3:0]  bes [3] = '{4'b1000, 4'b1000, 4'b1100};
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 1'b1, 1'b0, ads[i], f3s[i], 32'hFFFF_FFFF, 0, 32'h80FF_0000, o);
         n_cmp++;
         if (o.rdata !== exps[i] || o.err !== 1'b0) begin
            n_err++; $display("FAIL load%0d_data got %h err=%b want %h err=0", i, o.rdata, o.err, exps[i]);
         end
         n_cmp++;
         if (o.be !== bes[i] || o.addr !== 32'h200 || o.we !== 1'b0) begin
            n_err++;
            $display("FAIL load%0d_bus got be=%b addr=%h we=%b want %b 00000200 0",
                     i, o.be, o.addr, o.we, bes[i]);
         end
         n_cmp++;
         if (o.lat !== 2) begin
            n_err++; $display("FAIL load%0d_lat got %0d want 2", i, o.lat);
         end
      end
      exp_rdata = 32'h0000_80FF;
   endtask

   task automatic test_store();
      obs_t o;
      run_access(1'b0, 1'b0, 1'b1, 32'h301, 3'b000, 32'h1234_56AB, 1, 32'h7777_7777, o);
      n_cmp++;
      if (o.addr !== 32'h300 || o.be !== 4'b0010 || o.we !== 1'b1) begin
         n_err++;
         $display("FAIL sb_bus got addr=%h be=%b we=%b want 00000300 0010 1", o.addr, o.be, o.we);
      end
      n_cmp++;
      if (o.wdata !== 32'hABAB_ABAB) begin
         n_err++; $display("FAIL sb_wdata got %h want ababab ab", o.wdata);
      end
      n_cmp++;
      if (o.rdata !== exp_rdata || o.lat !== 3 || o.err !== 1'b0) begin
         n_err++;
         $display("FAIL sb_done got rdata=%h lat=%0d err=%b want %h 3 0", o.rdata, o.lat, o.err, exp_rdata);
      end
   endtask

   task automatic test_faults();
      obs_t        o;
      bit          ld  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b110, 3'b100};
      logic [31:0] ads [4] = '{32'h402, 32'h405, 32'h400, 32'h400};
      for (int i = 0; i < 4; i++) begin
         run_access(1'b0, ld[i], !ld[i], ads[i], f3s[i], 32'h1111_2222, 0, 32'h3333_4444, o);
         n_cmp++;
         if (o.req_seen || o.lat !== 1 || o.err !== 1'b1) begin
            n_err++;
            $display("FAIL fault%0d got req=%0d lat=%0d err=%b want 0 1 1", i, o.req_seen, o.lat, o.err);
         end
         n_cmp++;
         if (o.rdata !== 32'h0 || !o.width_ok) begin
            n_err++; $display("FAIL fault%0d_clr got rdata=%h width_ok=%0d want 0 1", i, o.rdata, o.width_ok);
         end
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_priority();
      @(negedge iClk);
      bus.iFetch = 1'b1; bus.iStore = 1'b1; bus.iAddr = 32'h500;
      bus.iFunct3 = 3'b010; bus.iWData = 32'hCAFE_F00D; bus.iBusAck = 1'b0;
      @(posedge iClk); #1;
      n_cmp++;
      if (bus.oBusReq !== 1'b1 || bus.oBusWe !== 1'b0 || bus.oBusAddr !== 32'h500) begin
         n_err++;
         $display("FAIL prio_fetch got req=%b we=%b addr=%h want 1 0 00000500",
                  bus.oBusReq, bus.oBusWe, bus.oBusAddr);
      end
      bus.iBusAck = 1'b1; bus.iBusRData = 32'h0BAD_C0DE;
      @(posedge iClk); #1;
      n_cmp++;
      if (bus.oRdy !== 1'b1 || bus.oRData !== 32'h0BAD_C0DE) begin
         n_err++; $display("FAIL prio_fdone got rdy=%b rdata=%h want 1 0badc0de", bus.oRdy, bus.oRData);
      end
      bus.iFetch = 1'b0; bus.iBusAck = 1'b0;
      @(posedge iClk); #1;
      n_cmp++;
      if (bus.oBusReq !== 1'b0 || bus.oRdy !== 1'b0) begin
         n_err++; $display("FAIL prio_idle got req=%b rdy=%b want 0 0", bus.oBusReq, bus.oRdy);
      end
      @(posedge iClk); #1;
      n_cmp++;
      if (bus.oBusReq !== 1'b1 || bus.oBusWe !== 1'b1 || bus.oBusWData !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL prio_store got req=%b we=%b wdata=%h want 1 1 cafef00d",
                  bus.oBusReq, bus.oBusWe, bus.oBusWData);
      end
      bus.iStore = 1'b0; bus.iBusAck = 1'b1;
      @(posedge iClk); #1;
      n_cmp++;
      if (bus.oRdy !== 1'b1 || bus.oErr !== 1'b0 || bus.oRData !== 32'h0BAD_C0DE) begin
         n_err++;
         $display("FAIL prio_sdone got rdy=%b err=%b rdata=%h want 1 0 0badc0de",
                  bus.oRdy, bus.oErr, bus.oRData);
      end
      bus.iBusAck = 1'b0;
      @(posedge iClk); #1;
      exp_rdata = 32'h0BAD_C0DE;
   endtask

   task automatic test_reset_mid();
      int rdy_seen;
      @(negedge iClk);
      bus.iLoad = 1'b1; bus.iAddr = 32'h600; bus.iFunct3 = 3'b010; bus.iBusAck = 1'b0;
      @(posedge iClk); #1;
      bus.iLoad = 1'b0;
      n_cmp++;
      if (bus.oBusReq !== 1'b1) begin
         n_err++; $display("FAIL rstmid_req got %b want 1", bus.oBusReq);
      end
      #2 nRst = 1'b0;
      #1;
      n_cmp++;
      if (bus.oBusReq !== 1'b0) begin
         n_err++; $display("FAIL rstmid_drop got %b want 0", bus.oBusReq);
      end
      @(negedge iClk);
      @(negedge iClk); nRst = 1'b1; bus.iBusAck = 1'b1; bus.iBusRData = 32'h1357_9BDF;
      rdy_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge iClk); #1;
         if (bus.oRdy === 1'b1 || bus.oBusReq === 1'b1) rdy_seen++;
      end
      bus.iBusAck = 1'b0;
      exp_rdata = 32'h0;
      n_cmp++;
      if (rdy_seen !== 0 || bus.oRData !== 32'h0) begin
         n_err++; $display("FAIL rstmid_abandon got activity=%0d rdata=%h want 0 0", rdy_seen, bus.oRData);
      end
   endtask

   task automatic test_random();
      obs_t        o;
      bit          f, l, s, is_st, fault, tmo, exp_err;
      logic [31:0] a, wd, rd, bw, ld, exp_rd;
      logic [3:0]  be;
      logic [2:0]  f3;
      int          waits, exp_lat;
      for (int i = 0; i < 150; i++) begin
         do begin
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 1) == 1);
         end while (!(f || l || s));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         wd = $urandom;
         rd = $urandom;
         waits = int'($urandom_range(0, 6));
         ref_model(f, l, f3, a, wd, rd, is_st, fault, be, bw, ld);
         tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
         tmo = !fault && (waits >= int'(TO));
`endif
         exp_lat = fault ? 1 : (tmo ? int'(TO) + 1 : waits + 2);
         exp_err = fault || tmo;
         exp_rd  = exp_err ? 32'h0 : (is_st ? exp_rdata : ld);
         run_access(f, l, s, a, f3, wd, waits, rd, o);
         n_cmp++;
         if (o.lat !== exp_lat || o.err !== exp_err || !o.width_ok) begin
            n_err++;
            $display("FAIL rnd%0d_done got lat=%0d err=%b w=%0d want %0d %b 1",
                     i, o.lat, o.err, o.width_ok, exp_lat, exp_err);
         end
         n_cmp++;
         if (o.rdata !== exp_rd) begin
            n_err++; $display("FAIL rnd%0d_rdata got %h want %h", i, o.rdata, exp_rd);
         end
         n_cmp++;
         if (o.req_seen !== !fault) begin
            n_err++; $display("FAIL rnd%0d_req got %0d want %0d", i, o.req_seen, !fault);
         end
         if (!fault) begin
            n_cmp++;
            if (o.we !== is_st || o.addr !== {a[31:2], 2'b00} || o.be !== be || !o.stable) begin
               n_err++;
               $display("FAIL rnd%0d_bus got we=%b addr=%h be=%b st=%0d want %b %h %b 1",
                        i, o.we, o.addr, o.be, o.stable, is_st, {a[31:2], 2'b00}, be);
            end
            if (is_st) begin
               n_cmp++;
               if (o.wdata !== bw) begin
                  n_err++; $display("FAIL rnd%0d_wdata got %h want %h", i, o.wdata, bw);
               end
            end
         end
         exp_rdata = exp_rd;
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      run_access(1'b0, 1'b1, 1'b0, 32'h700, 3'b010, 32'h0, 100, 32'h2468_ACE0, o);
      n_cmp++;
      if (!o.req_seen || o.lat !== int'(TO) + 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
         n_err++;
         $display("FAIL tmo_fault got req=%0d lat=%0d err=%b rdata=%h want 1 %0d 1 0",
                  o.req_seen, o.lat, o.err, o.rdata, TO + 1);
      end
      run_access(1'b0, 1'b1, 1'b0, 32'h700, 3'b010, 32'h0, int'(TO) - 1, 32'h2468_ACE0, o);
      n_cmp++;
      if (o.lat !== int'(TO) + 1 || o.err !== 1'b0 || o.rdata !== 32'h2468_ACE0) begin
         n_err++;
         $display("FAIL tmo_edge got lat=%0d err=%b rdata=%h want %0d 0 2468ace0",
                  o.lat, o.err, o.rdata, TO + 1);
      end
      exp_rdata = 32'h2468_ACE0;
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_loads();
      test_store();
      test_faults();
      test_priority();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
